id_exe_skid_reg: RTL and testbench
==================================

// Module: id_exe_skid_reg
// PURPOSE
//  ID->EXE pipeline register for the CPU's execute stage. Captures decoded operands and control
//  from the decode stage and presents eqa, b and ealuc directly to the ALU.
//  Valid/ready handshake on both sides, with a 2-entry skid buffer, so backpressure from EXE
//  never drops a decoded instruction. A synchronous flush squashes in-flight entries into
//  bubbles (branch/jump redirect).
// PARAMETERS
//  DATA_W  32  operand/immediate width (eqa, eqb, b, imm)
//  REG_W   5   destination register index width
// PORTS
//  clk       in   1       rising-edge clock
//  clrn      in   1       asynchronous active-low reset
//  d_valid   in   1       decode stage presents an instruction
//  d_ready   out  1       this block accepts it (registered, = !skid_full)
//  flush     in   1       squash all stored entries and any incoming one this cycle
//  dwreg     in   1       write-register-file control
//  dm2reg    in   1       memory-to-register select
//  dwmem     in   1       memory write enable
//  daluimm   in   1       1: ALU B operand = imm, 0: = qb
//  daluc     in   4       ALU op: 0010 add, 0110 sub, 0001 or, 0000 and, other xor
//  drd       in   REG_W   destination register
//  dqa       in   DATA_W  operand A
//  dqb       in   DATA_W  operand B (register)
//  dimm      in   DATA_W  sign/zero-extended immediate
//  e_valid   out  1       head entry valid toward EXE
//  e_ready   in   1       EXE consumes head entry
//  ewreg, em2reg, ewmem  out 1  head entry controls, gated: 0 when e_valid=0
//  ealuc     out  4       head entry ALU op
//  erd       out  REG_W   head entry destination
//  eqa       out  DATA_W  head entry operand A (to ALU eqa)
//  eqb       out  DATA_W  head entry operand B (store data for MEM)
//  b         out  DATA_W  ALU B operand = ealuimm ? eimm : eqb (combinational from head)
// BEHAVIOUR
//  - Storage: head (drives outputs) + skid; state EMPTY / ONE / TWO.
//  - Accept: d_valid & d_ready. Pop: e_valid & e_ready. Both evaluated on the same rising edge.
//  - EMPTY: accept -> ONE (load head).
//  - ONE: accept & pop -> ONE (head reloaded); accept & !pop -> TWO (load skid);
//    pop & !accept -> EMPTY.
//  - TWO: d_ready=0; pop -> ONE (skid moves to head); else hold.
//  - flush (highest priority): next state EMPTY, incoming instruction dropped, e_ready ignored.
//  - Latency: instruction accepted at edge N is visible on e_* after edge N when it lands in head.
//    Zero bubbles at full throughput (e_ready held 1).
//  - Order preserved; no duplication; no loss except by flush.
//  - Reset (clrn=0, async): state EMPTY, d_ready=1, e_valid=0, ewreg/em2reg/ewmem=0,
//    ealuc=4'b0010, erd=0, eqa=eqb=b=0. Reset mid-transfer discards all entries.
//  - Bubble/empty: control outputs forced 0 so no register or memory write can leak.
//    Data outputs hold their last value (don't care).
//  - Head data is stable while e_valid=1 and e_ready=0.
//  - daluc passed unmodified, including undefined codes.
// CONFIGURATION
//  IDEXE_PERF_CNT_EN defined: adds
//    out stall_cnt [31:0]: increments each cycle e_valid & !e_ready.
//    out flush_cnt [31:0]: increments each cycle flush=1 while state != EMPTY.
//    Both counters reset to 0 on clrn and wrap modulo 2^32.
//  Undefined: ports and logic absent; all other behaviour identical.
// TESTING
//  1 Reset: clrn=0 mid-run -> e_valid=0, d_ready=1, ealuc=0010, ewreg=0 immediately (before next clk).
//  2 Streaming: 4 back-to-back instrs, e_ready=1 -> emerge in order, 1 per cycle.
//    Instr dqa=5, dimm=3, daluimm=1, daluc=0010 -> eqa=5, b=3.
//  3 Backpressure: e_ready=0 while sending A,B -> state TWO, d_ready=0, head holds A.
//    e_ready=1 -> A then B delivered; C accepted once d_ready returns to 1.
//  4 Flush: state TWO, flush=1 with d_valid=1 -> next cycle e_valid=0, ewmem=0, state EMPTY;
//    dropped instr never appears.
//  5 Operand mux: daluimm=0, dqb=0xFFFF0000, dimm=0x10 -> b=0xFFFF0000, eqb=0xFFFF0000.
//  6 With IDEXE_PERF_CNT_EN: 3 stalled cycles then 1 flush of a non-empty stage
//    -> stall_cnt=3, flush_cnt=1.

Source files
------------

// File: rtl/id_exe_skid_reg_if.sv
// ID->EXE stage handoff bundle: decode-side inputs, handshake, and head-entry outputs toward EXE.
// slave: the pipeline register itself; master: the surrounding decode/execute environment.
interface id_exe_skid_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
);
    logic              d_valid;
    logic              d_ready;
    logic              flush;
    logic              dwreg;
    logic              dm2reg;
    logic              dwmem;
    logic              daluimm;
    logic [3:0]        daluc;
    logic [REG_W-1:0]  drd;
    logic [DATA_W-1:0] dqa;
    logic [DATA_W-1:0] dqb;
    logic [DATA_W-1:0] dimm;

    logic              e_valid;
    logic              e_ready;
    logic              ewreg;
    logic              em2reg;
    logic              ewmem;
    logic [3:0]        ealuc;
    logic [REG_W-1:0]  erd;
    logic [DATA_W-1:0] eqa;
    logic [DATA_W-1:0] eqb;
    logic [DATA_W-1:0] b;

    modport slave (
        input  d_valid, flush, dwreg, dm2reg, dwmem, daluimm, daluc, drd, dqa, dqb, dimm,
        input  e_ready,
        output d_ready,
        output e_valid, ewreg, em2reg, ewmem, ealuc, erd, eqa, eqb, b
    );

    modport master (
        output d_valid, flush, dwreg, dm2reg, dwmem, daluimm, daluc, drd, dqa, dqb, dimm,
        output e_ready,
        input  d_ready,
        input  e_valid, ewreg, em2reg, ewmem, ealuc, erd, eqa, eqb, b
    );
endinterface

// File: rtl/id_exe_skid_reg.sv
// ID->EXE pipeline register with a 2-entry skid buffer (head + skid) and synchronous flush.
// Optional IDEXE_PERF_CNT_EN adds stall_cnt / flush_cnt performance counters.
module id_exe_skid_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic        clk,
    input  logic        clrn,
    id_exe_skid_reg_if.slave bus
`ifdef IDEXE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic              wmem;
        logic              aluimm;
        logic [3:0]        aluc;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] qa;
        logic [DATA_W-1:0] qb;
        logic [DATA_W-1:0] imm;
    } entry_t;

    state_t state, state_nx;
    entry_t head, skid, din;
    logic   accept, pop;
    logic   load_head, load_skid, head_from_skid;
    logic   d_ready_i, e_valid_i;

    assign din = '{wreg: bus.dwreg, m2reg: bus.dm2reg, wmem: bus.dwmem, aluimm: bus.daluimm,
                   aluc: bus.daluc, rd: bus.drd, qa: bus.dqa, qb: bus.dqb, imm: bus.dimm};

    assign d_ready_i = (state != TWO);
    assign e_valid_i = (state != EMPTY);
    assign accept    = bus.d_valid & d_ready_i;
    assign pop       = e_valid_i & bus.e_ready;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= EMPTY;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        if (bus.flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nx  = ONE;
                    load_head = 1'b1;
                end
                ONE: begin
                    if (accept && pop) begin
                        load_head = 1'b1;
                    end else if (accept) begin
                        state_nx  = TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nx = EMPTY;
                    end
                end
                TWO: if (pop) begin
                    state_nx       = ONE;
                    load_head      = 1'b1;
                    head_from_skid = 1'b1;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            head      <= '0;
            head.aluc <= 4'b0010;
            skid      <= '0;
        end else begin
            if (load_head) head <= head_from_skid ? skid : din;
            if (load_skid) skid <= din;
        end
    end

    // Controls are gated by e_valid so a bubble can never write the register file or memory.
    assign bus.d_ready = d_ready_i;
    assign bus.e_valid = e_valid_i;
    assign bus.ewreg   = e_valid_i & head.wreg;
    assign bus.em2reg  = e_valid_i & head.m2reg;
    assign bus.ewmem   = e_valid_i & head.wmem;
    assign bus.ealuc   = head.aluc;
    assign bus.erd     = head.rd;
    assign bus.eqa     = head.qa;
    assign bus.eqb     = head.qb;
    assign bus.b       = head.aluimm ? head.imm : head.qb;

`ifdef IDEXE_PERF_CNT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (e_valid_i && !bus.e_ready)      stall_cnt <= stall_cnt + 32'd1;
            if (bus.flush && (state != EMPTY))  flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// Self-checking bench for id_exe_skid_reg: directed scenarios plus random traffic against a queue model.
// Define IDEXE_PERF_CNT_EN on both RTL and bench to exercise the performance counters.
module tb_id_exe_skid_reg;

    typedef struct {
        bit        wreg;
        bit        m2reg;
        bit        wmem;
        bit        aluimm;
        bit [3:0]  aluc;
        bit [4:0]  rd;
        bit [31:0] qa;
        bit [31:0] qb;
        bit [31:0] imm;
    } ent_t;

    logic clk;
    logic clrn;
    id_exe_skid_reg_if #(.DATA_W(32), .REG_W(5)) bus ();

`ifdef IDEXE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    id_exe_skid_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .clrn(clrn), .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
`else
    id_exe_skid_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .clrn(clrn), .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t        q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit [31:0]   m_stall  = 0;
    bit [31:0]   m_flush  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.wreg   = 1'($urandom);
        e.m2reg  = 1'($urandom);
        e.wmem   = 1'($urandom);
        e.aluimm = 1'($urandom);
        e.aluc   = 4'($urandom);
        e.rd     = 5'($urandom);
        e.qa     = $urandom;
        e.qb     = $urandom;
        e.imm    = $urandom;
        return e;
    endfunction

    task automatic drv(input bit v, input ent_t e);
        bus.d_valid = v;
        bus.dwreg   = e.wreg;
        bus.dm2reg  = e.m2reg;
        bus.dwmem   = e.wmem;
        bus.daluimm = e.aluimm;
        bus.daluc   = e.aluc;
        bus.drd     = e.rd;
        bus.dqa     = e.qa;
        bus.dqb     = e.qb;
        bus.dimm    = e.imm;
    endtask

    task automatic check_outputs();
        int unsigned sz;
        ent_t h;
        sz = q.size();
        chk("e_valid", 32'(bus.e_valid), 32'(sz > 0));
        chk("d_ready", 32'(bus.d_ready), 32'(sz < 2));
        if (sz > 0) begin
            h = q[0];
            chk("ewreg",  32'(bus.ewreg),  32'(h.wreg));
            chk("em2reg", 32'(bus.em2reg), 32'(h.m2reg));
            chk("ewmem",  32'(bus.ewmem),  32'(h.wmem));
            chk("ealuc",  32'(bus.ealuc),  32'(h.aluc));
            chk("erd",    32'(bus.erd),    32'(h.rd));
            chk("eqa",    bus.eqa,         h.qa);
            chk("eqb",    bus.eqb,         h.qb);
            chk("b",      bus.b,           h.aluimm ? h.imm : h.qb);
        end else begin
            chk("ewreg_bubble",  32'(bus.ewreg),  32'd0);
            chk("em2reg_bubble", 32'(bus.em2reg), 32'd0);
            chk("ewmem_bubble",  32'(bus.ewmem),  32'd0);
        end
`ifdef IDEXE_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
`endif
    endtask

    // One clock: check the current head against the model, then advance the model across the edge.
    task automatic cycle();
        bit   acc, pp, fl;
        ent_t e;
        check_outputs();
        acc      = bus.d_valid && (q.size() < 2);
        pp       = (q.size() > 0) && bus.e_ready;
        fl       = bus.flush;
        e.wreg   = bus.dwreg;   e.m2reg = bus.dm2reg; e.wmem = bus.dwmem;
        e.aluimm = bus.daluimm; e.aluc  = bus.daluc;  e.rd   = bus.drd;
        e.qa     = bus.dqa;     e.qb    = bus.dqb;    e.imm  = bus.dimm;
        if ((q.size() > 0) && !bus.e_ready) m_stall++;
        if (fl && (q.size() > 0))           m_flush++;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset();
        #2;
        clrn = 1'b0;
        #1;
        chk("rst_e_valid", 32'(bus.e_valid), 32'd0);
        chk("rst_d_ready", 32'(bus.d_ready), 32'd1);
        chk("rst_ealuc",   32'(bus.ealuc),   32'b0010);
        chk("rst_ewreg",   32'(bus.ewreg),   32'd0);
        chk("rst_em2reg",  32'(bus.em2reg),  32'd0);
        chk("rst_ewmem",   32'(bus.ewmem),   32'd0);
        chk("rst_erd",     32'(bus.erd),     32'd0);
        chk("rst_eqa",     bus.eqa,          32'd0);
        chk("rst_eqb",     bus.eqb,          32'd0);
        chk("rst_b",       bus.b,            32'd0);
`ifdef IDEXE_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        q.delete();
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ent_t e, a;
        clrn        = 1'b0;
        bus.flush   = 1'b0;
        bus.e_ready = 1'b0;
        e = '{default: 0};
        drv(1'b0, e);
        @(posedge clk);
        #1;
        do_reset();

        // Streaming: four back-to-back instructions at full throughput.
        bus.e_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = rnd_ent();
            if (i == 0) begin
                e.qa = 32'd5; e.imm = 32'd3; e.aluimm = 1'b1; e.aluc = 4'b0010;
            end
            drv(1'b1, e);
            cycle();
            if (i == 0) begin
                chk("stream_eqa", bus.eqa, 32'd5);
                chk("stream_b",   bus.b,   32'd3);
            end
        end
        drv(1'b0, e);
        cycle();
        cycle();

        // Backpressure: A and B fill head and skid, C waits for d_ready.
        bus.e_ready = 1'b0;
        a = rnd_ent();
        drv(1'b1, a);
        cycle();
        drv(1'b1, rnd_ent());
        cycle();
        chk("bp_d_ready", 32'(bus.d_ready), 32'd0);
        chk("bp_head_a",  bus.eqa, a.qa);
        drv(1'b1, rnd_ent());
        cycle();
        bus.e_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        drv(1'b0, e);
        for (int i = 0; i < 3; i++) cycle();

        // Flush from the full state with an incoming instruction that must be dropped.
        bus.e_ready = 1'b0;
        e = rnd_ent(); e.wmem = 1'b1;
        drv(1'b1, e);
        cycle();
        drv(1'b1, rnd_ent());
        cycle();
        drv(1'b1, rnd_ent());
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        drv(1'b0, e);
        chk("flush_e_valid", 32'(bus.e_valid), 32'd0);
        chk("flush_ewmem",   32'(bus.ewmem),   32'd0);
        chk("flush_d_ready", 32'(bus.d_ready), 32'd1);
        bus.e_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Operand mux selects the register operand when daluimm=0.
        e = rnd_ent();
        e.aluimm = 1'b0; e.qb = 32'hFFFF_0000; e.imm = 32'h10;
        bus.e_ready = 1'b0;
        drv(1'b1, e);
        cycle();
        drv(1'b0, e);
        chk("mux_b",   bus.b,   32'hFFFF_0000);
        chk("mux_eqb", bus.eqb, 32'hFFFF_0000);
        bus.e_ready = 1'b1;
        cycle();
        cycle();

        // Reset in the middle of a transfer discards everything.
        bus.e_ready = 1'b0;
        drv(1'b1, rnd_ent());
        cycle();
        cycle();
        drv(1'b0, e);
        do_reset();
        cycle();

`ifdef IDEXE_PERF_CNT_EN
        // Three stalled cycles, then one flush of a non-empty stage.
        do_reset();
        bus.e_ready = 1'b0;
        drv(1'b1, rnd_ent());
        cycle();
        drv(1'b0, e);
        for (int i = 0; i < 3; i++) cycle();
        bus.e_ready = 1'b1;
        bus.flush   = 1'b1;
        cycle();
        bus.flush   = 1'b0;
        chk("perf_stall_cnt", stall_cnt, 32'd3);
        chk("perf_flush_cnt", flush_cnt, 32'd1);
        cycle();
`endif

        // Random traffic with occasional flushes.
        for (int i = 0; i < 500; i++) begin
            drv(1'($urandom_range(0, 3) != 0), rnd_ent());
            bus.e_ready = 1'($urandom_range(0, 2) != 0);
            bus.flush   = ($urandom_range(0, 19) == 0);
            cycle();
        end
        bus.flush = 1'b0;
        drv(1'b0, e);
        bus.e_ready = 1'b1;
        cycle();
        cycle();
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
